// File: rtl/start_issuer_if.sv
// start_issuer_if: request and counter-start handshake bundle.
// master drives requests and counter status; slave is the issuer.
interface start_issuer_if #(
  parameter int REPEAT_W = 8
);
  logic                request__ENA;
  logic                request__RDY;
  logic [REPEAT_W-1:0] request_repeat;
  logic                startSignal__ENA;
  logic                startSignal__RDY;
  logic                busy;

  modport master (
    output request__ENA,
    output request_repeat,
    output startSignal__RDY,
    output busy,
    input  request__RDY,
    input  startSignal__ENA
  );

  modport slave (
    input  request__ENA,
    input  request_repeat,
    input  startSignal__RDY,
    input  busy,
    output request__RDY,
    output startSignal__ENA
  );
endinterface

// File: rtl/start_issuer.sv
// start_issuer: queues repeat-count requests and issues counter
// start pulses, one per repetition, counting completed runs.
module start_issuer #(
  parameter int DEPTH    = 4,
  parameter int REPEAT_W = 8,
  parameter int DONE_W   = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  start_issuer_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [DONE_W-1:0]          doneCount,
  output logic                       idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH+1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [REPEAT_W-1:0] mem [DEPTH];
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic [AW:0]         occ;
  logic [1:0]          state;
  logic [REPEAT_W-1:0] remaining;
  logic [REPEAT_W-1:0] head;
  logic                empty;
  logic                full;
  logic                wr;
  logic                ena;
  logic                run_done;
  logic                pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign occ   = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  assign wr       = bus.request__ENA && !full;
  assign ena      = (state == ISSUE) && bus.startSignal__RDY;
  assign run_done = (state == WAIT) && !bus.busy;
  // Next entry is taken when idle, or when the last run of the
  // active request has just completed.
  assign pop = !empty && ((state == IDLE) ||
               (run_done && (remaining == '0)));

  assign bus.request__RDY     = !full;
  assign bus.startSignal__ENA = ena;
  assign pending              = PW'(occ);
  assign idle                 = (state == IDLE) && empty;

  // Request storage; contents need no reset, pointers gate validity.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[AW-1:0]] <= bus.request_repeat;
  end

  // FIFO pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Issue FSM: a zero-repeat entry is dropped without a start.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      remaining <= '0;
      doneCount <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (pop) begin
            remaining <= head;
            state     <= (head == '0) ? IDLE : ISSUE;
          end
        end
        (state == ISSUE): begin
          if (ena) begin
            remaining <= remaining - REPEAT_W'(1);
            state     <= WAIT;
          end
        end
        (state == WAIT): begin
          if (run_done) begin
            doneCount <= doneCount + DONE_W'(1);
            if (remaining != '0) begin
              state <= ISSUE;
            end else if (pop) begin
              remaining <= head;
              state     <= (head == '0) ? IDLE : ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_start_issuer.sv
// tb_start_issuer: scoreboard bench with a decrementing
// counter model answering the start pulses.
module tb_start_issuer;
  localparam int DEPTH = 4;
  localparam int RW    = 8;
  localparam int DW    = 4;

  typedef struct {
    int done;
    int m;
  } exp_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [2:0]    pending;
  logic [DW-1:0] doneCount;
  logic          idle;

  start_issuer_if #(.REPEAT_W(RW)) ifc();

  start_issuer #(
    .DEPTH(DEPTH), .REPEAT_W(RW), .DONE_W(DW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (ifc),
    .pending   (pending),
    .doneCount (doneCount),
    .idle      (idle)
  );

  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   ena_cyc[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   model_done = 0;
  int   cnt;
  int   cur_m = 1;
  logic rdy_gate = 1'b1;

  assign ifc.busy             = (cnt != 0);
  assign ifc.startSignal__RDY = (cnt == 0) && rdy_gate;

  // cycle index
  always @(posedge CLK) cyc <= cyc + 1;

  // counter model: loads M-1 on a start, counts down to zero
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt <= 0;
    else if (ifc.startSignal__ENA) cnt <= cur_m - 1;
    else if (cnt != 0) cnt <= cnt - 1;
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // monitor: each start pulse pops one expected run
  always @(negedge CLK) begin
    if (nRST && ifc.startSignal__ENA) begin
      exp_t e;
      ena_cyc.push_back(cyc);
      chk("ena_with_rdy", int'(ifc.startSignal__RDY), 1);
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ena: got pulse at cycle %0d expected none",
                 cyc);
        cur_m = 1;
      end else begin
        e = sb.pop_front();
        chk("done_at_ena", int'(doneCount), e.done);
        cur_m = e.m;
      end
    end
  end

  int last_enq;

  task automatic enq(input int r, input int m, output bit acc);
    @(negedge CLK);
    ifc.request__ENA   = 1'b1;
    ifc.request_repeat = RW'(r);
    last_enq = cyc;
    #1 acc = ifc.request__RDY;
    if (acc) begin
      for (int i = 0; i < r; i++) begin
        sb.push_back('{model_done % (1 << DW), m});
        model_done++;
      end
    end
    @(posedge CLK);
    #1 ifc.request__ENA = 1'b0;
  endtask

  task automatic enq_retry(input int r, input int m);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      enq(r, m, acc);
      n++;
    end
    chk("enq_accepted", int'(acc), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(idle && sb.size() == 0 && cnt == 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_in_time", int'(n < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ifc.request__ENA = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("rst_ena", int'(ifc.startSignal__ENA), 0);
    chk("rst_req_rdy", int'(ifc.request__RDY), 1);
    chk("rst_pending", int'(pending), 0);
    chk("rst_done", int'(doneCount), 0);
    chk("rst_idle", int'(idle), 1);
    sb.delete();
    ena_cyc.delete();
    model_done = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int t;
    int reps[6];
    bit exp_acc[6];
    ifc.request__ENA   = 1'b0;
    ifc.request_repeat = '0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // 1: asynchronous reset
    do_reset();

    // 2: one request, three runs of M=22
    enq(3, 22, acc);
    t = last_enq;
    chk("t2_acc", int'(acc), 1);
    wait_drain(200);
    chk("t2_n_ena", ena_cyc.size(), 3);
    if (ena_cyc.size() == 3) begin
      chk("t2_first_lat", ena_cyc[0] - t, 2);
      chk("t2_period1", ena_cyc[1] - ena_cyc[0], 23);
      chk("t2_period2", ena_cyc[2] - ena_cyc[1], 23);
    end
    chk("t2_done", int'(doneCount), 3);
    chk("t2_idle", int'(idle), 1);

    // 3: RDY held low, six back-to-back requests
    do_reset();
    rdy_gate = 1'b0;
    reps = '{1, 2, 1, 1, 1, 1};
    exp_acc = '{1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      enq(reps[i], i + 2, acc);
      chk($sformatf("t3_acc%0d", i), int'(acc), int'(exp_acc[i]));
    end
    @(negedge CLK);
    chk("t3_req_rdy", int'(ifc.request__RDY), 0);
    chk("t3_pending", int'(pending), 4);
    chk("t3_no_ena", ena_cyc.size(), 0);
    rdy_gate = 1'b1;
    wait_drain(200);
    chk("t3_n_ena", ena_cyc.size(), 6);
    chk("t3_done", int'(doneCount), 6);
    chk("t3_pending_end", int'(pending), 0);

    // 4: zero-repeat entry is dropped
    do_reset();
    enq(0, 5, acc);
    enq(1, 5, acc);
    wait_drain(100);
    chk("t4_n_ena", ena_cyc.size(), 1);
    chk("t4_done", int'(doneCount), 1);

    // 5: reset during WAIT with two queued
    do_reset();
    enq(1, 30, acc);
    enq(1, 30, acc);
    enq(1, 30, acc);
    begin
      int n;
      n = 0;
      while (ena_cyc.size() == 0 && n < 20) begin
        @(negedge CLK);
        n++;
      end
      chk("t5_ena_seen", int'(n < 20), 1);
    end
    repeat (3) @(negedge CLK);
    chk("t5_pending_pre", int'(pending), 2);
    chk("t5_idle_pre", int'(idle), 0);
    do_reset();
    repeat (40) @(negedge CLK);
    chk("t5_no_ena", ena_cyc.size(), 0);
    chk("t5_done", int'(doneCount), 0);
    chk("t5_pending", int'(pending), 0);

    // 6: doneCount wrap with M=1 runs
    do_reset();
    for (int i = 0; i < 17; i++) enq_retry(1, 1);
    wait_drain(200);
    chk("t6_n_ena", ena_cyc.size(), 17);
    chk("t6_done_wrap", int'(doneCount), 1);
    for (int i = 1; i < ena_cyc.size(); i++)
      chk($sformatf("t6_period%0d", i),
          ena_cyc[i] - ena_cyc[i-1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
